// File: rtl/mmio_host.sv
// mmio_host: memory-mapped host block with TOHOST exit flag, console TX FIFO and status.
// Define MMIO_HOST_CYCLE_COUNTER_EN to add the 64-bit CYCLE_LO/CYCLE_HI counter.
module mmio_host #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        suspend,
    output logic [30:0] exit_code,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [31:0] tohost, status;
    logic [63:0] cycle;
    logic [5:0]  off;
    logic        overflow, wr, push_req, push, pop, full, empty, unused;

    assign unused   = ^dataadr[1:0];
    assign hit      = dataadr[31:8] == 24'hFFFF00;
    assign off      = dataadr[7:2];
    assign wr       = memwrite && hit && !suspend;
    assign empty    = count == '0;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign pop      = tx_valid && tx_ready;
    assign push_req = wr && off == 6'd1;
    // a full FIFO still accepts a byte when the head leaves on the same edge
    assign push     = push_req && (!full || pop);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : mem[rp];
    assign status   = {24'h0, 5'(count), overflow, empty, full};

    assign readdata = !hit       ? 32'h0 :
                      off == 6'd0 ? tohost :
                      off == 6'd2 ? status :
                      off == 6'd3 ? cycle[31:0] :
                      off == 6'd4 ? cycle[63:32] : 32'h0;

    always_ff @(posedge clk)
        if (push) mem[wp] <= writedata[7:0];

    always_ff @(posedge clk or posedge areset)
        if (areset) begin
            tohost    <= '0;
            suspend   <= 1'b0;
            exit_code <= '0;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr && off == 6'd0) begin
                tohost <= writedata;
                if (writedata[0]) begin
                    suspend   <= 1'b1;
                    exit_code <= writedata[31:1];
                end
            end
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // a new overflow wins over a same-cycle clear
            overflow <= (push_req && full && !pop) ||
                        (overflow && !(wr && off == 6'd2 && writedata[2]));
        end

`ifdef MMIO_HOST_CYCLE_COUNTER_EN
    always_ff @(posedge clk or posedge areset)
        if (areset) cycle <= '0;
        else if (!suspend) cycle <= cycle + 64'd1;
`else
    assign cycle = '0;
`endif
endmodule

// File: tb/tb_mmio_host.sv
// tb_mmio_host: directed self-checking bench for mmio_host (FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_mmio_host;
    localparam logic [31:0] TOHOST = 32'hFFFF0000;
    localparam logic [31:0] TXDATA = 32'hFFFF0004;
    localparam logic [31:0] STATUS = 32'hFFFF0008;
    localparam logic [31:0] CYC_LO = 32'hFFFF000C;
    localparam logic [31:0] CYC_HI = 32'hFFFF0010;
`ifdef MMIO_HOST_CYCLE_COUNTER_EN
    localparam logic [31:0] CYC_EXP = 32'd101;
`else
    localparam logic [31:0] CYC_EXP = 32'd0;
`endif

    logic        clk = 1'b0, areset = 1'b1, memwrite = 1'b0, tx_ready = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0, readdata;
    logic        hit, suspend, tx_valid;
    logic [30:0] exit_code;
    logic [7:0]  tx_data;
    int          errors = 0, checks = 0;

    mmio_host #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .areset(areset), .dataadr(dataadr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .hit(hit), .suspend(suspend),
        .exit_code(exit_code), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        dataadr = adr;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        dataadr   = adr;
        writedata = d;
        memwrite  = 1'b1;
        @(negedge clk);
        memwrite  = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] drain [4];
        drain = '{8'h42, 8'h43, 8'h44, 8'h5A};
        step();
        chk("rst_suspend", {31'h0, suspend}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_exit_code", {1'b0, exit_code}, 32'h0);
        chk_rd("rst_status", STATUS, 32'h02);
        areset = 1'b0;
        step();
        chk_rd("unmapped_0x20", 32'hFFFF0020, 32'h0);
        chk("hit_0x20", {31'h0, hit}, 32'h1);
        chk_rd("miss_0x100", 32'h00000100, 32'h0);
        chk("hit_0x100", {31'h0, hit}, 32'h0);
        chk_rd("status_byte_alias", 32'hFFFF000B, 32'h02);

        wr(TXDATA, 32'hDEADBE41);
        chk("fifo_head_A", {24'h0, tx_data}, 32'h41);
        chk_rd("status_cnt1", STATUS, 32'h08);
        wr(TXDATA, 32'h42);
        wr(TXDATA, 32'h43);
        wr(TXDATA, 32'h44);
        chk_rd("status_full", STATUS, 32'h21);
        wr(TXDATA, 32'h45);
        chk_rd("status_overflow", STATUS, 32'h25);
        chk("stall_head_A", {24'h0, tx_data}, 32'h41);
        wr(STATUS, 32'h4);
        chk_rd("status_w1c", STATUS, 32'h21);

        tx_ready = 1'b1;
        wr(TXDATA, 32'h5A);
        tx_ready = 1'b0;
        chk_rd("full_push_pop_status", STATUS, 32'h21);
        chk("full_push_pop_head", {24'h0, tx_data}, 32'h42);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_%0d", i), {23'h0, tx_valid, tx_data}, {24'h1, drain[i]});
            step();
        end
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);
        chk_rd("drained_status", STATUS, 32'h02);

        wr(TXDATA, 32'h51);
        chk("nobypass_head", {23'h0, tx_valid, tx_data}, 32'h151);
        tx_ready = 1'b0;
        step();
        step();
        chk("stall_stable", {23'h0, tx_valid, tx_data}, 32'h151);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("stall_drained", {31'h0, tx_valid}, 32'h0);

        wr(TXDATA, 32'h01);
        wr(TXDATA, 32'h02);
        wr(TXDATA, 32'h03);
        chk_rd("three_queued", STATUS, 32'h18);
        wr(TOHOST, 32'h8);
        chk("tohost_bit0_clear", {31'h0, suspend}, 32'h0);
        chk_rd("tohost_latch8", TOHOST, 32'h8);
        wr(TOHOST, 32'h15);
        chk("suspend_set", {31'h0, suspend}, 32'h1);
        chk("exit_code_10", {1'b0, exit_code}, 32'd10);
        chk_rd("tohost_0x15", TOHOST, 32'h15);
        wr(TXDATA, 32'h44);
        chk_rd("suspend_blocks_push", STATUS, 32'h18);
        wr(TOHOST, 32'h3);
        chk_rd("suspend_blocks_tohost", TOHOST, 32'h15);
        chk("suspend_exit_held", {1'b0, exit_code}, 32'd10);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("suspend_drain_head", {24'h0, tx_data}, 32'h02);
        chk_rd("suspend_drain_status", STATUS, 32'h10);

        #2 areset = 1'b1;
        #1;
        chk("async_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("async_tx_data", {24'h0, tx_data}, 32'h0);
        chk("async_suspend", {31'h0, suspend}, 32'h0);
        chk("async_exit_code", {1'b0, exit_code}, 32'h0);
        chk_rd("async_status", STATUS, 32'h02);
        chk_rd("async_tohost", TOHOST, 32'h0);
        step();
        areset = 1'b0;
        wr(TXDATA, 32'h4D);
        chk("post_reset_first", {23'h0, tx_valid, tx_data}, 32'h14D);
        chk_rd("post_reset_status", STATUS, 32'h08);

        areset = 1'b1;
        #1 areset = 1'b0;
        chk_rd("cycle_after_reset", CYC_LO, 32'h0);
        repeat (100) step();
        wr(TOHOST, 32'h1);
        chk("cycle_suspend", {31'h0, suspend}, 32'h1);
        chk_rd("cycle_lo", CYC_LO, CYC_EXP);
        repeat (10) step();
        chk_rd("cycle_lo_frozen", CYC_LO, CYC_EXP);
        chk_rd("cycle_hi", CYC_HI, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
